// File: rtl/pingpong_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_clk_pkg
// Description : Shared state encoding and default widths for the ping-pong
//               clock generator and the register slave that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
package pingpong_clk_pkg;

    localparam int PP_CNT_W_DEFAULT  = 16;
    localparam int PP_DEAD_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PH_A    = 3'd1,
        DEAD_AB = 3'd2,
        PH_B    = 3'd3,
        DEAD_BA = 3'd4,
        DONE    = 3'd5
    } pp_state_e;

endpackage
`default_nettype wire

// File: rtl/pp_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pp_down_counter
// Description : Loadable down-counter that stops at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - C_ONE;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pingpong_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_clk_gen
// Description : Non-overlapping two-phase (ping/pong) pulse burst generator
//               with programmable phase width, dead time and pair count.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_clk_gen
    import pingpong_clk_pkg::*;
#(
    parameter int CNT_W  = PP_CNT_W_DEFAULT,
    parameter int DEAD_W = PP_DEAD_W_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [CNT_W-1:0]  cfg_half_period,
    input  logic [DEAD_W-1:0] cfg_dead_time,
    input  logic [CNT_W-1:0]  cfg_pulse_count,
    input  logic              start,
    input  logic              stop,
    output logic              clk_a,
    output logic              clk_b,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pairs_done
);

    localparam logic [CNT_W-1:0]  C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DEAD_W-1:0] C_DEAD_ONE = {{(DEAD_W-1){1'b0}}, 1'b1};

    pp_state_e         state_q, state_d;
    logic [CNT_W-1:0]  hp_q, hp_d;          // phase reload value, max(hp,1)-1
    logic [DEAD_W-1:0] dt_q, dt_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]  pairs_q, pairs_d;
    logic              stop_pend_q, stop_pend_d;
    logic              clk_a_q, clk_b_q, busy_q, done_q;

    logic              w_ph_load, w_ph_dec, w_ph_zero;
    logic [CNT_W-1:0]  w_ph_load_val;
    logic              w_dt_load, w_dt_dec, w_dt_zero;
    logic [DEAD_W-1:0] w_dt_load_val;
    logic [CNT_W-1:0]  w_hp_reload;

    // A zero half period behaves as one cycle, so fold that into the reload.
    assign w_hp_reload = (cfg_half_period == '0) ? '0 : (cfg_half_period - C_CNT_ONE);

    // Next-state, configuration latch, pair count and stop bookkeeping.
    always_comb begin
        state_d       = state_q;
        hp_d          = hp_q;
        dt_d          = dt_q;
        pc_d          = pc_q;
        pairs_d       = pairs_q;
        stop_pend_d   = stop_pend_q;
        w_ph_load     = 1'b0;
        w_ph_dec      = 1'b0;
        w_ph_load_val = hp_q;
        w_dt_load     = 1'b0;
        w_dt_dec      = 1'b0;
        w_dt_load_val = dt_q - C_DEAD_ONE;

        if ((state_q != IDLE) && (state_q != DONE)) begin
            stop_pend_d = stop_pend_q | stop;
        end

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    hp_d          = w_hp_reload;
                    dt_d          = cfg_dead_time;
                    pc_d          = cfg_pulse_count;
                    pairs_d       = '0;
                    stop_pend_d   = stop;
                    state_d       = PH_A;
                    w_ph_load     = 1'b1;
                    w_ph_load_val = w_hp_reload;
                end
            end
            PH_A: begin
                if (w_ph_zero) begin
                    if (dt_q == '0) begin
                        state_d   = PH_B;
                        w_ph_load = 1'b1;
                    end else begin
                        state_d   = DEAD_AB;
                        w_dt_load = 1'b1;
                    end
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            DEAD_AB: begin
                if (w_dt_zero) begin
                    state_d   = PH_B;
                    w_ph_load = 1'b1;
                end else begin
                    w_dt_dec = 1'b1;
                end
            end
            PH_B: begin
                if (w_ph_zero) begin
                    pairs_d = pairs_q + C_CNT_ONE;
                    // A stop arriving in this very cycle still ends the burst here.
                    if (((pc_q != '0) && (pairs_d == pc_q)) || stop_pend_q || stop) begin
                        state_d = DONE;
                    end else if (dt_q == '0) begin
                        state_d   = PH_A;
                        w_ph_load = 1'b1;
                    end else begin
                        state_d   = DEAD_BA;
                        w_dt_load = 1'b1;
                    end
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            DEAD_BA: begin
                if (w_dt_zero) begin
                    state_d   = PH_A;
                    w_ph_load = 1'b1;
                end else begin
                    w_dt_dec = 1'b1;
                end
            end
            DONE: begin
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, configuration and registered outputs decoded from the next state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            hp_q        <= '0;
            dt_q        <= '0;
            pc_q        <= '0;
            pairs_q     <= '0;
            stop_pend_q <= 1'b0;
            clk_a_q     <= 1'b0;
            clk_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            dt_q        <= dt_d;
            pc_q        <= pc_d;
            pairs_q     <= pairs_d;
            stop_pend_q <= stop_pend_d;
            clk_a_q     <= (state_d == PH_A);
            clk_b_q     <= (state_d == PH_B);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    pp_down_counter #(.W(CNT_W)) u_phase_cnt (
        .clk        (ACLK),
        .rst        (ARESET),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_load_val),
        .i_dec      (w_ph_dec),
        .o_zero     (w_ph_zero)
    );

    pp_down_counter #(.W(DEAD_W)) u_dead_cnt (
        .clk        (ACLK),
        .rst        (ARESET),
        .i_load     (w_dt_load),
        .i_load_val (w_dt_load_val),
        .i_dec      (w_dt_dec),
        .o_zero     (w_dt_zero)
    );

    assign clk_a      = clk_a_q;
    assign clk_b      = clk_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pairs_done = pairs_q;

endmodule
`default_nettype wire
